// File: rtl/window_tuple_feeder.sv
// Window-tuple source for the first stream-join core: buffers upstream tuples in a
// small FIFO and hands them on with the valid MSB set, bounded to window_length per pass.
// Optional stall counter: define WINDOW_FEEDER_STALL_CNT_EN.
`ifndef PARA_WINDOW_TUPLE_WIDTH
`define PARA_WINDOW_TUPLE_WIDTH 33
`endif

module window_tuple_feeder #(
  parameter int WINDOW_TUPLE_WIDTH = `PARA_WINDOW_TUPLE_WIDTH,
  parameter int FIFO_DEPTH         = 4,
  parameter int COUNT_WIDTH        = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          start,
  input  logic [COUNT_WIDTH-1:0]        window_length,
  input  logic [WINDOW_TUPLE_WIDTH-2:0] s_tuple_data,
  input  logic                          s_tuple_valid,
  output logic                          s_tuple_ready,
  input  logic                          window_stage_full_input,
  output logic [WINDOW_TUPLE_WIDTH-1:0] window_tuple_output,
  output logic                          busy,
  output logic                          done,
  output logic [COUNT_WIDTH-1:0]        sent_count,
  output logic [31:0]                   stall_count,
  output logic [1:0]                    debug_state
);

  // Upstream: a tuple moves when s_tuple_valid & s_tuple_ready at the rising edge;
  // ready comes from registered state only. Downstream: a tuple moves when the output
  // valid bit is set and window_stage_full_input is low; the head holds otherwise.

  localparam int PW = WINDOW_TUPLE_WIDTH - 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            occ_q;
  logic [COUNT_WIDTH-1:0] len_q, acc_q, sent_q;

  logic fifo_full, fifo_nempty, push, pop, last_xfer, start_pass;

  assign fifo_full   = (occ_q == DEPTH_C);
  assign fifo_nempty = (occ_q != '0);
  assign start_pass  = (state_q == S_IDLE) && start;
  assign push        = s_tuple_valid && s_tuple_ready;
  assign pop         = (state_q == S_RUN) && fifo_nempty && !window_stage_full_input;
  assign last_xfer   = pop && ((sent_q + COUNT_WIDTH'(1)) == len_q);

  assign sent_count  = sent_q;
  assign debug_state = state_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (window_length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_xfer) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_tuple_ready       = 1'b0;
    busy                = 1'b0;
    done                = 1'b0;
    window_tuple_output = fifo_nempty ? {1'b1, mem_q[rd_ptr_q]} : '0;
    case (state_q)
      S_RUN: begin
        busy          = 1'b1;
        s_tuple_ready = !fifo_full && (acc_q < len_q);
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_tuple_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      sent_q   <= '0;
    end else begin
      if (start_pass) begin
        len_q  <= window_length;
        acc_q  <= '0;
        sent_q <= '0;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        acc_q    <= acc_q + COUNT_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        sent_q   <= sent_q + COUNT_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef WINDOW_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge aclk) begin
    if (areset || start_pass) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && fifo_nempty && window_stage_full_input &&
                 (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_window_tuple_feeder.sv
// Directed bench for window_tuple_feeder: reset, in-order streaming, back-pressure,
// window bound, zero-length pass and mid-pass reset, with hand-computed expectations.
module tb_window_tuple_feeder;

  localparam int W  = 9;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start;
  logic [CW-1:0] window_length;
  logic [W-2:0]  s_tuple_data;
  logic          s_tuple_valid;
  logic          s_tuple_ready;
  logic          full_in;
  logic [W-1:0]  win_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_count;
  logic [31:0]   stall_count;
  logic [1:0]    debug_state;

  int checks   = 0;
  int failures = 0;
  int acc_n, sent_n, offer_n, done_n;
  logic [7:0] base_v;
  logic [31:0] exp_stall;

  window_tuple_feeder #(
    .WINDOW_TUPLE_WIDTH(W),
    .FIFO_DEPTH(4),
    .COUNT_WIDTH(CW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .start(start),
    .window_length(window_length),
    .s_tuple_data(s_tuple_data),
    .s_tuple_valid(s_tuple_valid),
    .s_tuple_ready(s_tuple_ready),
    .window_stage_full_input(full_in),
    .window_tuple_output(win_out),
    .busy(busy),
    .done(done),
    .sent_count(sent_count),
    .stall_count(stall_count),
    .debug_state(debug_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Upstream driver plus downstream collector: offers base_v+k for k < offer_n,
  // checks every transfer in order, stops at done or when the budget runs out.
  task automatic pump(input string tag, input int budget);
    logic a, x, seen;
    logic [W-1:0] e;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      a = s_tuple_ready && s_tuple_valid;
      x = win_out[W-1] && !full_in;
      if (x) begin
        e = {1'b1, 8'(base_v + sent_n)};
        check({tag, "_xfer"}, 32'(win_out), 32'(e));
        sent_n++;
      end
      step();
      if (a) acc_n++;
      if (acc_n < offer_n) begin
        s_tuple_valid = 1'b1;
        s_tuple_data  = 8'(base_v + acc_n);
      end else begin
        s_tuple_valid = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
`ifdef WINDOW_FEEDER_STALL_CNT_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    areset = 1'b1; start = 1'b0; window_length = '0;
    s_tuple_data = '0; s_tuple_valid = 1'b0; full_in = 1'b0;
    step(); step();
    areset = 1'b0;

    // Reset and idle
    for (int i = 0; i < 5; i++) step();
    check("rst_out",   32'(win_out), 32'd0);
    check("rst_ready", 32'(s_tuple_ready), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_sent",  32'(sent_count), 32'd0);
    check("rst_stall", stall_count, 32'd0);
    check("rst_state", 32'(debug_state), 32'd0);

    // Length 3, consecutive transfers A, B, C
    start = 1'b1; window_length = 16'd3; s_tuple_valid = 1'b1; s_tuple_data = 8'h0A;
    step();
    start = 1'b0;
    check("t3_busy",  32'(busy), 32'd1);
    check("t3_ready", 32'(s_tuple_ready), 32'd1);
    step();
    check("t3_a", 32'(win_out), 32'h10A);
    s_tuple_data = 8'h0B;
    step();
    check("t3_b", 32'(win_out), 32'h10B);
    s_tuple_data = 8'h0C;
    step();
    check("t3_c", 32'(win_out), 32'h10C);
    check("t3_ready_off", 32'(s_tuple_ready), 32'd0);
    s_tuple_valid = 1'b0;
    step();
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy_done", 32'(busy), 32'd0);
    check("t3_out_empty", 32'(win_out), 32'd0);
    check("t3_sent", 32'(sent_count), 32'd3);
    step();
    check("t3_done_pulse", 32'(done), 32'd0);
    check("t3_sent_hold", 32'(sent_count), 32'd3);

    // Length 8 with the stage full for 10 cycles after the first tuple appears
    base_v = 8'h00; acc_n = 0; sent_n = 0; offer_n = 8;
    start = 1'b1; window_length = 16'd8; s_tuple_valid = 1'b1; s_tuple_data = 8'h00;
    step();
    start = 1'b0;
    step();
    acc_n = 1; s_tuple_data = 8'h01;
    check("bp_first", 32'(win_out), 32'h100);
    full_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (s_tuple_ready) begin
        step();
        acc_n++;
        s_tuple_data = 8'(acc_n);
      end else begin
        step();
      end
    end
    check("bp_accepts", 32'(acc_n), 32'd4);
    check("bp_ready_low", 32'(s_tuple_ready), 32'd0);
    check("bp_head_hold", 32'(win_out), 32'h100);
    check("bp_stall", stall_count, exp_stall);
    check("bp_sent_zero", 32'(sent_count), 32'd0);
    full_in = 1'b0;
    pump("bp", 40);
    check("bp_all_sent", 32'(sent_n), 32'd8);
    check("bp_sent", 32'(sent_count), 32'd8);
    check("bp_stall_hold", stall_count, exp_stall);
    step();

    // Length 2 with 5 tuples offered: only 2 accepted
    base_v = 8'h20; acc_n = 0; sent_n = 0; offer_n = 5;
    start = 1'b1; window_length = 16'd2; s_tuple_valid = 1'b1; s_tuple_data = 8'h20;
    step();
    start = 1'b0;
    check("wl_stall_clear", stall_count, 32'd0);
    pump("wl", 20);
    check("wl_accepted", 32'(acc_n), 32'd2);
    check("wl_sent", 32'(sent_count), 32'd2);
    check("wl_pending", 32'(s_tuple_valid), 32'd1);
    check("wl_ready_low", 32'(s_tuple_ready), 32'd0);
    step();
    check("wl_ready_idle", 32'(s_tuple_ready), 32'd0);
    check("wl_data_pending", 32'(s_tuple_data), 32'h22);

    // Zero-length pass
    done_n = 0;
    start = 1'b1; window_length = 16'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("z_ready", 32'(s_tuple_ready), 32'd0);
      if (done) done_n++;
      step();
    end
    check("z_done_once", 32'(done_n), 32'd1);
    check("z_sent", 32'(sent_count), 32'd0);
    check("z_busy", 32'(busy), 32'd0);
    s_tuple_valid = 1'b0;

    // Reset in RUN with 3 tuples buffered
    start = 1'b1; window_length = 16'd5; full_in = 1'b1;
    s_tuple_valid = 1'b1; s_tuple_data = 8'h40;
    step();
    start = 1'b0;
    step(); step(); step();
    check("mr_buffered", 32'(win_out), 32'h140);
    check("mr_busy_run", 32'(busy), 32'd1);
    areset = 1'b1;
    step();
    areset = 1'b0; s_tuple_valid = 1'b0; full_in = 1'b0;
    check("mr_out", 32'(win_out), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_ready", 32'(s_tuple_ready), 32'd0);
    check("mr_sent", 32'(sent_count), 32'd0);
    step();
    check("mr_no_done", 32'(done), 32'd0);
    check("mr_still_empty", 32'(win_out), 32'd0);

    base_v = 8'h50; acc_n = 0; sent_n = 0; offer_n = 1;
    start = 1'b1; window_length = 16'd1; s_tuple_valid = 1'b1; s_tuple_data = 8'h50;
    step();
    start = 1'b0;
    pump("mr_fresh", 20);
    check("mr_fresh_sent", 32'(sent_count), 32'd1);
    check("mr_fresh_count", 32'(sent_n), 32'd1);
    step();
    check("mr_fresh_idle", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
